// File: rtl/set_pkg.sv
// Shared definitions for the SET lattice-count host: field widths, mode codes,
// operand bundle and FSM state encoding.
package set_pkg;
    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int CAND_W    = 8;

    localparam logic [1:0] MODE_A    = 2'b00;
    localparam logic [1:0] MODE_AND  = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_TWO3 = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } set_op_t;
endpackage

// File: rtl/set_job_fifo.sv
// Job descriptor FIFO: power-of-two circular buffer with an occupancy count
// that separates full from empty.
module set_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q + PTR_W'(do_push);
        rptr_d  = rptr_q + PTR_W'(do_pop);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/set_host.sv
// Initiator for the SET lattice-count interface: queues jobs, issues them one at a
// time, waits for the done pulse or a timeout, and returns the tagged result.
module set_host
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023,
    parameter int TAG_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CENTRAL_W-1:0] job_central,
    input  logic [RADIUS_W-1:0]  job_radius,
    input  logic [MODE_W-1:0]    job_mode,
    input  logic [TAG_W-1:0]     job_tag,
    output logic                 set_en,
    output logic [CENTRAL_W-1:0] set_central,
    output logic [RADIUS_W-1:0]  set_radius,
    output logic [MODE_W-1:0]    set_mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CAND_W-1:0]    set_candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CAND_W-1:0]    res_candidate,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_timeout,
    output logic                 stray_valid,
    output logic                 idle
);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int JOB_W  = $bits(set_op_t) + TAG_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    set_op_t           op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CAND_W-1:0] cand_q, cand_d;
    logic              to_q, to_d;
    logic              stray_q, stray_d;
    logic              idle_q, idle_d;
    logic              push, pop, full, empty;
    logic [FCNT_W-1:0] fcount, fcount_nxt;
    logic [JOB_W-1:0]  head;

    assign push = job_valid && !full;

    set_job_fifo #(
        .DEPTH (DEPTH),
        .W     (JOB_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({job_central, job_radius, job_mode, job_tag}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fcount)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        cand_d  = cand_q;
        to_d    = to_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !set_busy) begin
                    pop           = 1'b1;
                    {op_d, tag_d} = head;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse on the last allowed cycle still counts as an answer.
                if (set_valid) begin
                    cand_d  = set_candidate;
                    to_d    = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cand_d  = '0;
                    to_d    = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        stray_d    = stray_q || (set_valid && (state_q != ST_WAIT));
        // idle is registered from next-state values so it reads 0 while in reset.
        fcount_nxt = fcount + FCNT_W'(push) - FCNT_W'(pop);
        idle_d     = (fcount_nxt == '0) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            cand_q  <= '0;
            to_q    <= 1'b0;
            stray_q <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            cand_q  <= cand_d;
            to_q    <= to_d;
            stray_q <= stray_d;
            idle_q  <= idle_d;
        end
    end

    assign job_ready     = !full;
    assign set_en        = (state_q == ST_ISSUE);
    assign set_central   = op_q.central;
    assign set_radius    = op_q.radius;
    assign set_mode      = op_q.mode;
    assign res_valid     = (state_q == ST_RESP);
    assign res_candidate = cand_q;
    assign res_tag       = tag_q;
    assign res_timeout   = to_q;
    assign stray_valid   = stray_q;
    assign idle          = idle_q;
endmodule
